// File: rtl/bound_flasher_monitor.sv
// Passive checker for the bound flasher LED bus: decodes the thermometer code,
// follows the six-segment up/down sequence (with flick kickbacks) and flags
// protocol violations. Every output is registered.
module bound_flasher_monitor #(
    parameter int unsigned ERR_CNT_W = 8,
    parameter int unsigned SEQ_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          LED,
    input  logic                 flick,
    output logic                 active,
    output logic [2:0]           phase,
    output logic                 dir,
    output logic [4:0]           lit_cnt,
    output logic                 kick,
    output logic                 seq_done,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [SEQ_CNT_W-1:0] seq_cnt
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StResync
    } state_e;

    state_e     state;
    logic       hold_exp;
    logic [4:0] prev_cnt;

    logic       legal;
    logic [4:0] n;
    logic [4:0] bound;
    logic       step_ok;
    logic       advance;
    logic       last;
    logic       kick_ok;

    // Turning point of each segment: max for up phases, min for down phases.
    function automatic logic [4:0] seg_bound(input logic [2:0] p);
        case (p)
            3'd0:    seg_bound = 5'd16;
            3'd1:    seg_bound = 5'd5;
            3'd2:    seg_bound = 5'd11;
            3'd3:    seg_bound = 5'd0;
            3'd4:    seg_bound = 5'd7;
            default: seg_bound = 5'd0;
        endcase
    endfunction

    // Thermometer decode: LED is legal only when it equals (1<<n)-1.
    always_comb begin
        logic [16:0] t;
        legal = 1'b0;
        n     = 5'd0;
        t     = 17'd0;
        for (int i = 0; i <= 16; i++) begin
            t = (17'd1 << i) - 17'd1;
            if ({1'b0, LED} == t) begin
                legal = 1'b1;
                n     = 5'(i);
            end
        end
    end

    // Expected-step check for the RUN state; even phases count up, odd count down.
    always_comb begin
        bound   = seg_bound(phase);
        step_ok = 1'b0;
        advance = 1'b0;
        last    = 1'b0;
        if (hold_exp) begin
            step_ok = (n == prev_cnt);
        end else if (!phase[0]) begin
            if (prev_cnt < bound) begin
                step_ok = (n == prev_cnt + 5'd1);
            end else begin
                step_ok = (n == prev_cnt - 5'd1);
                advance = 1'b1;
            end
        end else if (prev_cnt > bound) begin
            step_ok = (n == prev_cnt - 5'd1);
        end else if (phase != 3'd5) begin
            step_ok = (n == prev_cnt + 5'd1);
            advance = 1'b1;
        end else begin
            step_ok = (n == 5'd0);
            last    = 1'b1;
        end
        kick_ok = flick && (phase == 3'd1 || phase == 3'd3) && (n == 5'd0 || n == 5'd5);
    end

    // Sequence tracker FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= StIdle;
            hold_exp <= 1'b0;
            prev_cnt <= 5'd0;
            active   <= 1'b0;
            phase    <= 3'd0;
            dir      <= 1'b1;
            lit_cnt  <= 5'd0;
            kick     <= 1'b0;
            seq_done <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'd0;
            err_cnt  <= '0;
            seq_cnt  <= '0;
        end else begin
            kick     <= 1'b0;
            seq_done <= 1'b0;
            err      <= 1'b0;
            lit_cnt  <= legal ? n : 5'd0;
            case (state)
                StIdle: begin
                    if (LED != 16'd0) begin
                        err      <= 1'b1;
                        err_code <= 2'd3;
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        state    <= StResync;
                    end else if (flick) begin
                        state    <= StRun;
                        active   <= 1'b1;
                        phase    <= 3'd0;
                        dir      <= 1'b1;
                        hold_exp <= 1'b1;
                        prev_cnt <= 5'd0;
                    end
                end
                StRun: begin
                    if (!legal || !step_ok) begin
                        err      <= 1'b1;
                        err_code <= legal ? 2'd2 : 2'd1;
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        state    <= StResync;
                        active   <= 1'b0;
                        phase    <= 3'd0;
                        dir      <= 1'b1;
                        hold_exp <= 1'b0;
                    end else begin
                        prev_cnt <= n;
                        hold_exp <= 1'b0;
                        if (kick_ok) begin
                            // Kickback wins over a segment advance in the same cycle.
                            phase    <= phase - 3'd1;
                            dir      <= phase[0];
                            hold_exp <= 1'b1;
                            kick     <= 1'b1;
                        end else if (last) begin
                            seq_done <= 1'b1;
                            seq_cnt  <= seq_cnt + 1'b1;
                            state    <= StIdle;
                            active   <= 1'b0;
                            phase    <= 3'd0;
                            dir      <= 1'b1;
                        end else if (advance) begin
                            phase <= phase + 3'd1;
                            dir   <= phase[0];
                        end
                    end
                end
                StResync: begin
                    // Flick is ignored here even when LED clears.
                    if (LED == 16'd0) state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_bound_flasher_monitor.sv
// Directed bench for bound_flasher_monitor with an expected-output scoreboard.
module tb_bound_flasher_monitor;

    logic        clk;
    logic        rst;
    logic [15:0] LED;
    logic        flick;
    logic        active;
    logic [2:0]  phase;
    logic        dir;
    logic [4:0]  lit_cnt;
    logic        kick;
    logic        seq_done;
    logic        err;
    logic [1:0]  err_code;
    logic [7:0]  err_cnt;
    logic [7:0]  seq_cnt;

    bound_flasher_monitor #(
        .ERR_CNT_W(8),
        .SEQ_CNT_W(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .LED      (LED),
        .flick    (flick),
        .active   (active),
        .phase    (phase),
        .dir      (dir),
        .lit_cnt  (lit_cnt),
        .kick     (kick),
        .seq_done (seq_done),
        .err      (err),
        .err_code (err_code),
        .err_cnt  (err_cnt),
        .seq_cnt  (seq_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       active;
        logic [2:0] phase;
        logic       dir;
        logic [4:0] lit;
        logic       kick;
        logic       done;
        logic       err;
        logic [1:0] code;
        logic [7:0] ecnt;
        logic [7:0] scnt;
    } exp_t;

    exp_t       sb[$];
    int         tests  = 0;
    int         failed = 0;
    logic [1:0] e_code = 2'd0;
    logic [7:0] e_ecnt = 8'd0;
    logic [7:0] e_scnt = 8'd0;

    function automatic logic [15:0] th(input int cnt);
        logic [16:0] t;
        t = (17'd1 << cnt) - 17'd1;
        return t[15:0];
    endfunction

    task automatic push(input logic act, input logic [2:0] ph, input logic [4:0] lit,
                        input logic k, input logic d, input logic e, input logic [1:0] c);
        exp_t x;
        if (e) begin
            e_code = c;
            if (e_ecnt != 8'hFF) e_ecnt = e_ecnt + 8'd1;
        end
        if (d) e_scnt = e_scnt + 8'd1;
        x = '{active: act, phase: ph, dir: ~ph[0], lit: lit, kick: k, done: d, err: e,
              code: e_code, ecnt: e_ecnt, scnt: e_scnt};
        sb.push_back(x);
    endtask

    task automatic check(input string tag);
        exp_t ex;
        exp_t ob;
        tests++;
        if (sb.size() == 0) begin
            failed++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            ex = sb.pop_front();
            ob = exp_t'({active, phase, dir, lit_cnt, kick, seq_done, err, err_code,
                         err_cnt, seq_cnt});
            assert (ob === ex) else begin
                failed++;
                $error("FAIL %s: observed %h expected %h", tag, ob, ex);
            end
        end
    endtask

    task automatic step(input logic [15:0] led_v, input logic fl, input logic [4:0] lit,
                        input logic act, input logic [2:0] ph, input logic k,
                        input logic d, input logic e, input logic [1:0] c, input string tag);
        LED   = led_v;
        flick = fl;
        push(act, ph, lit, k, d, e, c);
        @(posedge clk);
        #1;
        check(tag);
        flick = 1'b0;
    endtask

    task automatic run_n(input int cnt, input logic fl, input int ph, input logic k,
                         input string tag);
        step(th(cnt), fl, 5'(cnt), 1'b1, 3'(ph), k, 1'b0, 1'b0, 2'd0, tag);
    endtask

    // Drive every count after 'from' up to and including 'to' within one segment.
    task automatic seg(input int ph, input int from, input int to);
        if (to > from) begin
            for (int v = from + 1; v <= to; v++) run_n(v, 1'b0, ph, 1'b0, "seg_up");
        end else begin
            for (int v = from - 1; v >= to; v--) run_n(v, 1'b0, ph, 1'b0, "seg_down");
        end
    endtask

    task automatic start_seq();
        step(16'd0, 1'b1, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, "start");
        step(16'd0, 1'b0, 5'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 2'd0, "start_hold");
    endtask

    task automatic idle_step(input logic [15:0] led_v, input logic fl, input logic [4:0] lit,
                             input logic e, input logic [1:0] c, input string tag);
        step(led_v, fl, lit, 1'b0, 3'd0, 1'b0, 1'b0, e, c, tag);
    endtask

    initial begin
        rst   = 1'b1;
        LED   = 16'd0;
        flick = 1'b0;
        #3;
        push(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        check("reset");
        @(negedge clk);
        rst = 1'b0;
        idle_step(16'd0, 1'b0, 5'd0, 1'b0, 2'd0, "idle");

        // Plain legal sequence.
        start_seq();
        seg(0, 0, 16);
        seg(1, 16, 5);
        seg(2, 5, 11);
        seg(3, 11, 0);
        seg(4, 0, 7);
        seg(5, 7, 0);
        step(16'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0, "seq_done1");
        idle_step(16'd0, 1'b0, 5'd0, 1'b0, 2'd0, "idle_after1");

        // Kickbacks in phases 1 and 3, ignored flick in phase 5.
        start_seq();
        seg(0, 0, 16);
        seg(1, 16, 6);
        run_n(5, 1'b1, 0, 1'b1, "kick_ph1");
        run_n(5, 1'b0, 0, 1'b0, "kick_ph1_hold");
        seg(0, 5, 16);
        seg(1, 16, 5);
        seg(2, 5, 11);
        seg(3, 11, 1);
        run_n(0, 1'b1, 2, 1'b1, "kick_ph3");
        run_n(0, 1'b0, 2, 1'b0, "kick_ph3_hold");
        seg(2, 0, 11);
        seg(3, 11, 0);
        seg(4, 0, 7);
        seg(5, 7, 6);
        run_n(5, 1'b1, 5, 1'b0, "flick_ph5_ignored");
        seg(5, 5, 0);
        step(16'd0, 1'b0, 5'd0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 2'd0, "seq_done2");

        // Illegal code, recovery, clean restart.
        start_seq();
        seg(0, 0, 3);
        idle_step(16'h0005, 1'b0, 5'd0, 1'b1, 2'd1, "illegal_code");
        idle_step(16'd0, 1'b0, 5'd0, 1'b0, 2'd0, "resync_exit");

        // Wrong step, quiet resync, flick refused on resync exit.
        start_seq();
        seg(0, 0, 4);
        idle_step(th(6), 1'b0, 5'd6, 1'b1, 2'd2, "wrong_step");
        idle_step(16'h0005, 1'b0, 5'd0, 1'b0, 2'd0, "resync_quiet");
        idle_step(16'd0, 1'b1, 5'd0, 1'b0, 2'd0, "resync_flick");
        idle_step(16'd0, 1'b0, 5'd0, 1'b0, 2'd0, "idle_no_run");
        idle_step(th(3), 1'b0, 5'd3, 1'b1, 2'd3, "idle_nonzero");
        idle_step(16'd0, 1'b0, 5'd0, 1'b0, 2'd0, "resync_exit2");

        // Error counter saturation.
        for (int i = 0; i < 300; i++) begin
            idle_step(16'h0001, 1'b0, 5'd1, 1'b1, 2'd3, "sat_err");
            idle_step(16'd0, 1'b0, 5'd0, 1'b0, 2'd0, "sat_clear");
        end

        // Asynchronous reset in phase 2.
        start_seq();
        seg(0, 0, 16);
        seg(1, 16, 5);
        seg(2, 5, 8);
        rst    = 1'b1;
        e_code = 2'd0;
        e_ecnt = 8'd0;
        e_scnt = 8'd0;
        push(1'b0, 3'd0, 5'd0, 1'b0, 1'b0, 1'b0, 2'd0);
        #1;
        check("async_rst");
        @(negedge clk);
        rst = 1'b0;
        idle_step(16'd0, 1'b0, 5'd0, 1'b0, 2'd0, "idle_after_rst");
        start_seq();
        seg(0, 0, 2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
